data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-port data memory between the pipeline MEM stage and a debug/loader port. The CPU has priority. A debug request that has been blocked for STARVE_LIMIT cycles is granted by force, and the pipeline is stalled for that one cycle. The block sits between the MEM stage and the data memory instance: it drives the memory address, write data and write-enable, and returns read data to both requesters.

## Interface
- STARVE_LIMIT, 4: number of consecutive cycles a debug request may be denied before a forced grant. 0 means the debug port always wins on its first request cycle.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage has a load or store this cycle
- cpu_we  in  1  CPU access is a store
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data, already lane-merged
- cpu_rdata  out  32  combinational copy of mem_spo; valid only when cpu_req=1 and cpu_stall=0
- cpu_stall  out  1  combinational; CPU access not serviced this cycle, so the pipeline holds EX/MEM
- dbg_req  in  1  debug request; must be held high with stable dbg_we, dbg_addr and dbg_wdata until dbg_ack
- dbg_we  in  1  debug access is a write
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug write data
- dbg_ack  out  1  registered one-cycle completion pulse
- dbg_rdata  out  32  registered read data; valid while dbg_ack=1, held otherwise
- mem_a  out  32  memory address
- mem_d  out  32  memory write data
- mem_we  out  1  memory write enable, sampled by the memory on the rising edge of clk
- mem_spo  in  32  asynchronous memory read data

## Operation
- State machine: S_IDLE (no debug request pending), S_WAIT (debug request pending and denied), S_ACK (debug access done, ack cycle).
- Counter wait_cnt, width $clog2(STARVE_LIMIT+1) with a minimum of 1, saturates at STARVE_LIMIT.
- grant_dbg is combinational: (state is S_IDLE or S_WAIT) & dbg_req & (~cpu_req | wait_cnt==STARVE_LIMIT).
- When grant_dbg=1:
  - Outputs: mem_a=dbg_addr, mem_d=dbg_wdata, mem_we=dbg_we, cpu_stall=cpu_req.
  - Registered: dbg_rdata <= mem_spo, wait_cnt <= 0, next state S_ACK.
- When grant_dbg=0:
  - mem_a=cpu_addr, mem_d=cpu_wdata, mem_we=cpu_req&cpu_we, cpu_stall=0.
- Transitions:
  - S_IDLE/S_WAIT with dbg_req=1 and not granted: next S_WAIT, wait_cnt <= min(wait_cnt+1, STARVE_LIMIT).
  - S_IDLE/S_WAIT with dbg_req=0: next S_IDLE, wait_cnt <= 0. An abandoned request produces no ack.
  - S_ACK: dbg_ack=1, dbg_req is ignored, the CPU owns the port unconditionally, next S_IDLE. The requester may drop dbg_req in this cycle. If dbg_req is still high in the following cycle, it is a new request.
- At most one memory write per cycle; the CPU and debug port are never both written.
- A debug request is granted at most once per dbg_req assertion, via the S_ACK interlock.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state=S_IDLE, wait_cnt=0, dbg_ack=0, dbg_rdata=0.
  - cpu_stall and mem_we are forced to 0 while rst_n is low, regardless of inputs.
- Reset during S_WAIT or S_ACK drops the pending or acked transaction immediately; the requester must reissue it.
- CPU access latency: 0 cycles when not stalled. A store commits at the edge ending the cycle; load data is combinational in the same cycle.
- Debug latency:
  - Uncontended: grant in the cycle dbg_req is first seen high, dbg_ack in the next cycle.
  - Contended with cpu_req held high: grant at cycle STARVE_LIMIT after the request, ack one cycle later.
- Forced grant stalls the CPU for exactly one cycle. The CPU is never stalled in two consecutive cycles by this block.
- Simultaneous cpu_req and dbg_req in S_IDLE with STARVE_LIMIT>0: the CPU wins and wait_cnt becomes 1.
- cpu_req dropping while in S_WAIT: debug is granted that cycle regardless of wait_cnt.

## Test plan
- Uncontended debug write: cpu_req=0; dbg_req=1, dbg_we=1, dbg_addr=0x40, dbg_wdata=0xDEADBEEF at cycle 0 -> mem_we=1 with mem_a=0x40 at cycle 0, dbg_ack=1 at cycle 1, memory word 0x40 reads 0xDEADBEEF.
- Starvation: STARVE_LIMIT=4, cpu_req=1 continuously, dbg read of 0x40 from cycle 0 -> cpu_stall=0 for cycles 0-3, cpu_stall=1 only at cycle 4, dbg_ack=1 and dbg_rdata=0xDEADBEEF at cycle 5, cpu_stall=0 at cycle 5.
- Early release: cpu_req=1 for cycles 0-1 and 0 at cycle 2, dbg_req from cycle 0 -> grant at cycle 2 with no stall, ack at cycle 3, wait_cnt=0 afterwards.
- Back-to-back requests: dbg_req held high through ack -> no access during S_ACK. A second grant occurs at cycle 2 if cpu_req=0, giving exactly two dbg_ack pulses.
- CPU store/load: cpu_req=1, cpu_we=1, addr 0x10, data 0x12345678, then a load of 0x10 -> cpu_rdata=0x12345678 with cpu_stall=0 and dbg_ack staying 0.
- Reset mid-operation: rst_n low during S_WAIT (wait_cnt=2) with dbg_req=1 and cpu_req=1 -> cpu_stall=0 and mem_we=0 immediately. After release: state S_IDLE, wait_cnt restarts from 0, forced grant at 4 cycles after reset release.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage and the debug/loader port.
// The CPU wins ties; a starved debug request is force-granted and stalls the CPU for one cycle.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  input  logic [31:0] mem_spo
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          starved;
  logic          grant_dbg;

  assign starved   = (wait_cnt == LIMIT);
  assign grant_dbg = ((state == S_IDLE) || (state == S_WAIT)) && dbg_req && (!cpu_req || starved);

  // rst_n gates the write/stall outputs so nothing leaks to memory or pipeline during reset
  assign mem_a     = grant_dbg ? dbg_addr  : cpu_addr;
  assign mem_d     = grant_dbg ? dbg_wdata : cpu_wdata;
  assign mem_we    = rst_n && (grant_dbg ? dbg_we : (cpu_req && cpu_we));
  assign cpu_stall = rst_n && grant_dbg && cpu_req;
  assign cpu_rdata = mem_spo;

  always_comb begin
    state_nxt    = S_IDLE;
    wait_cnt_nxt = '0;
    if (state == S_ACK) begin
      state_nxt    = S_IDLE;
      wait_cnt_nxt = '0;
    end else if (grant_dbg) begin
      state_nxt    = S_ACK;
      wait_cnt_nxt = '0;
    end else if (dbg_req) begin
      state_nxt    = S_WAIT;
      wait_cnt_nxt = starved ? wait_cnt : wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      dbg_ack  <= grant_dbg;
      if (grant_dbg) dbg_rdata <= mem_spo;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Random-stimulus scoreboard bench for data_mem_arbiter with a small behavioural memory.
module tb_data_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [31:0] mem_a, mem_d, mem_spo;
  logic        mem_we;

  always #5 clk = ~clk;

  data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
  );

  // 64-word memory, word index from address bits [7:2]
  logic [31:0] mem [64] = '{default: 32'h0};
  assign mem_spo = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_d;

  typedef struct {
    logic        stall;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } cyc_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } dbg_exp_t;

  cyc_exp_t    exp_q[$];
  dbg_exp_t    dbg_q[$];
  logic [31:0] ref_mem [64];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  // monitor: one expected record per live cycle, plus debug acks matched by cycle
  initial begin : mon
    cyc_exp_t e;
    dbg_exp_t d;
    logic     ack_due;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, e.stall});
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_a", mem_a, e.a);
          chk("mem_d", mem_d, e.d);
          if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rdata);
        end
        ack_due = (dbg_q.size() != 0) && (dbg_q[0].cyc == cyc);
        chk("dbg_ack", {31'b0, dbg_ack}, {31'b0, ack_due});
        if (ack_due) begin
          d = dbg_q.pop_front();
          chk("dbg_rdata", dbg_rdata, d.rdata);
        end
      end
    end
  end

  // stimulus and reference model
  initial begin : drv
    int   denied;
    bit   in_ack, prev_stall, win, quiesce;
    int   mode;
    cyc_exp_t e;

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = rnd_addr(); cpu_wdata = $urandom;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = rnd_addr(); dbg_wdata = $urandom;
    #2;
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_ack", {31'b0, dbg_ack}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    dbg_req = 1'b0;
    denied = 0; in_ack = 0; prev_stall = 0; mode = 0; quiesce = 0;

    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) mode = $urandom_range(0, 2);
      quiesce = (c >= 2990);

      if (c == 1500) begin
        // asynchronous reset with both requesters active
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_ack", {31'b0, dbg_ack}, 32'd0);
        chk("mid_rst_rdata", dbg_rdata, 32'd0);
        @(posedge clk); #1;
        cyc++;
        rst_n = 1'b1;
        dbg_q.delete();
        denied = 0; in_ack = 0; prev_stall = 0;
        mode = 0;
      end

      if (!prev_stall) begin
        case (mode)
          0:       cpu_req = 1'b1;
          1:       cpu_req = ($urandom_range(0, 7) == 0);
          default: cpu_req = $urandom_range(0, 1) != 0;
        endcase
        cpu_we = $urandom_range(0, 1) != 0;
        cpu_addr = rnd_addr();
        cpu_wdata = $urandom;
      end

      if (quiesce) dbg_req = 1'b0;
      else if (in_ack || !dbg_req) begin
        if ((in_ack && $urandom_range(0, 1) == 0) || (!in_ack && $urandom_range(0, 3) == 0)) begin
          dbg_req = 1'b1;
          dbg_we = $urandom_range(0, 1) != 0;
          dbg_addr = rnd_addr();
          dbg_wdata = $urandom;
        end else dbg_req = 1'b0;
      end else if ($urandom_range(0, 15) == 0) dbg_req = 1'b0;

      // debug wins when the port is free of the ack cycle and the CPU is idle or has starved it
      win = !in_ack && dbg_req && (!cpu_req || denied >= LIMIT);
      e.stall = win && cpu_req;
      if (win) begin
        e.we = dbg_we; e.a = dbg_addr; e.d = dbg_wdata;
        dbg_q.push_back('{cyc: cyc + 1, rdata: ref_mem[dbg_addr[7:2]]});
      end else begin
        e.we = cpu_req && cpu_we; e.a = cpu_addr; e.d = cpu_wdata;
      end
      e.chk_rd = cpu_req && !cpu_we && !e.stall;
      e.rdata = ref_mem[cpu_addr[7:2]];
      exp_q.push_back(e);
      if (e.we) ref_mem[e.a[7:2]] = e.d;

      if (win) denied = 0;
      else if (dbg_req && !in_ack) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
      else denied = 0;
      in_ack = win;
      prev_stall = e.stall;

      @(posedge clk); #1;
      cyc++;
    end

    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    for (int i = 0; i < 64; i++) chk("mem_word", mem[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
